qpsk_frame_parser: RTL and testbench

Receive-side frame parser sitting directly downstream of `qpsk_mod_demod`. It consumes the 40-bit recovered parallel word `para_out` plus a one-cycle frame strobe. It checks the 0xFF header and 0xFF tail bytes, then serialises the three payload bytes into a byte FIFO with a valid/ready output stream. Malformed frames are rejected, and frames that cannot be accepted are dropped, with a status pulse in each case.

---
 rtl/qpsk_pkg.sv | 30 +++
 rtl/qpsk_frame_parser_if.sv | 26 ++
 rtl/qpsk_byte_fifo.sv | 73 +++++++
 rtl/qpsk_frame_parser.sv | 153 +++++++++++++++
 tb/tb_qpsk_frame_parser.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive-side frame parser: FSM encoding,
// frame field positions, default delimiters and a frame delimiter check.
package qpsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PUSH0 = 2'd1,
        ST_PUSH1 = 2'd2,
        ST_PUSH2 = 2'd3
    } parser_state_e;

    localparam int FRAME_W  = 40;
    localparam int HDR_MSB  = 39;
    localparam int HDR_LSB  = 32;
    localparam int PAY_MSB  = 31;
    localparam int PAY_LSB  = 8;
    localparam int TAIL_MSB = 7;
    localparam int TAIL_LSB = 0;

    localparam logic [7:0] DEFAULT_HEADER = 8'hFF;
    localparam logic [7:0] DEFAULT_TAIL   = 8'hFF;
    localparam int         PAYLOAD_BYTES  = 3;

    function automatic logic frame_ok(input logic [FRAME_W-1:0] frame,
                                      input logic [7:0] hdr,
                                      input logic [7:0] tail);
        return (frame[HDR_MSB:HDR_LSB] == hdr) && (frame[TAIL_MSB:TAIL_LSB] == tail);
    endfunction

endpackage

// File: rtl/qpsk_frame_parser_if.sv
// Frame-in / byte-stream-out bundle of the frame parser. The slave modport is the
// parser; the master modport is the demodulator/consumer side driving it.
interface qpsk_frame_parser_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [39:0]      para_in;
    logic             para_vld;
    logic [7:0]       byte_out;
    logic             byte_vld;
    logic             byte_rdy;
    logic             frame_err;
    logic             frame_drop;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output para_in, para_vld, byte_rdy,
        input  byte_out, byte_vld, frame_err, frame_drop, fifo_level
    );

    modport slave (
        input  para_in, para_vld, byte_rdy,
        output byte_out, byte_vld, frame_err, frame_drop, fifo_level
    );
endinterface

// File: rtl/qpsk_byte_fifo.sv
// Synchronous show-ahead byte FIFO; fullness is tracked by an occupancy count so
// pointers can simply wrap modulo DEPTH.
module qpsk_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             vld,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok_s, pop_ok_s;

    assign pop_ok_s  = pop && (level_q != {LVL_W{1'b0}});
    assign push_ok_s = push && ((level_q != LVL_W'(DEPTH)) || pop_ok_s);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign vld   = (level_q != {LVL_W{1'b0}});
    assign head  = vld ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign level = level_q;

endmodule

// File: rtl/qpsk_frame_parser.sv
// Receive frame parser: checks header/tail of each 40-bit frame and serialises the
// three payload bytes into a show-ahead FIFO. Optional counters: QPSK_PARSER_STATS_EN.
module qpsk_frame_parser
    import qpsk_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] HEADER     = DEFAULT_HEADER,
    parameter logic [7:0] TAIL       = DEFAULT_TAIL
) (
    input  logic                clk,
    input  logic                rst,
`ifdef QPSK_PARSER_STATS_EN
    output logic [15:0]         ok_cnt,
    output logic [15:0]         err_cnt,
`endif
    qpsk_frame_parser_if.slave  bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SP_W  = LVL_W + 1;

    parser_state_e    state_q, state_d;
    logic [23:0]      payload_q, payload_d;
    logic             frame_err_q, frame_err_d;
    logic             frame_drop_q, frame_drop_d;
    logic             push_s, pop_s, good_s, room_s;
    logic [7:0]       push_data_s;
    logic [LVL_W-1:0] level_s;
    logic [SP_W-1:0]  free_s;

    assign good_s = frame_ok(bus.para_in, HEADER, TAIL);
    assign pop_s  = bus.byte_vld && bus.byte_rdy;
    // A byte leaving this cycle frees its slot in time for the first payload write
    assign free_s = SP_W'(FIFO_DEPTH) - {1'b0, level_s} + {{(SP_W-1){1'b0}}, pop_s};
    assign room_s = (free_s >= SP_W'(PAYLOAD_BYTES));

    // State and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            payload_q    <= 24'h000000;
            frame_err_q  <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            payload_q    <= payload_d;
            frame_err_q  <= frame_err_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.para_vld && good_s && room_s) begin
                    state_d = ST_PUSH0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH0: state_d = ST_PUSH1;
            ST_PUSH1: state_d = ST_PUSH2;
            ST_PUSH2: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: payload capture, FIFO writes, status pulses
    always_comb begin
        payload_d    = payload_q;
        frame_err_d  = 1'b0;
        frame_drop_d = 1'b0;
        push_s       = 1'b0;
        push_data_s  = 8'h00;
        if (bus.para_vld) begin
            if (!good_s) begin
                frame_err_d = 1'b1;
            end else if ((state_q != ST_IDLE) || !room_s) begin
                frame_drop_d = 1'b1;
            end else begin
                frame_drop_d = 1'b0;
            end
        end else begin
            frame_err_d = 1'b0;
        end
        if ((state_q == ST_IDLE) && bus.para_vld) begin
            payload_d = bus.para_in[PAY_MSB:PAY_LSB];
        end else begin
            payload_d = payload_q;
        end
        case (state_q)
            ST_PUSH0: begin push_s = 1'b1; push_data_s = payload_q[23:16]; end
            ST_PUSH1: begin push_s = 1'b1; push_data_s = payload_q[15:8];  end
            ST_PUSH2: begin push_s = 1'b1; push_data_s = payload_q[7:0];   end
            default:  begin push_s = 1'b0; push_data_s = 8'h00;            end
        endcase
    end

    qpsk_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (bus.byte_out),
        .vld       (bus.byte_vld),
        .level     (level_s)
    );

    assign bus.fifo_level = level_s;
    assign bus.frame_err  = frame_err_q;
    assign bus.frame_drop = frame_drop_q;

`ifdef QPSK_PARSER_STATS_EN
    logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

    // Saturating statistics next-state
    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if ((state_q == ST_IDLE) && (state_d == ST_PUSH0) && (ok_cnt_q != 16'hFFFF)) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end else begin
            ok_cnt_d = ok_cnt_q;
        end
        if ((frame_err_d || frame_drop_d) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ok_cnt_q  <= 16'h0000;
            err_cnt_q <= 16'h0000;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ok_cnt  = ok_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_qpsk_frame_parser.sv
// Directed self-checking bench for qpsk_frame_parser (FIFO_DEPTH = 16).
module tb_qpsk_frame_parser;
    logic clk = 1'b0;
    logic rst;
    int   cmp_cnt = 0;
    int   mis_cnt = 0;

    qpsk_frame_parser_if #(.FIFO_DEPTH(16)) bus ();

`ifdef QPSK_PARSER_STATS_EN
    logic [15:0] ok_cnt, err_cnt;
    qpsk_frame_parser #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .ok_cnt(ok_cnt), .err_cnt(err_cnt), .bus(bus.slave)
    );
`else
    qpsk_frame_parser #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            mis_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [39:0] frame);
        bus.para_in  = frame;
        bus.para_vld = 1'b1;
        tick();
        bus.para_vld = 1'b0;
    endtask

    function automatic logic [39:0] mk_frame(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2);
        return {8'hFF, b0, b1, b2, 8'hFF};
    endfunction

    initial begin
        rst          = 1'b1;
        bus.para_in  = 40'h0;
        bus.para_vld = 1'b0;
        bus.byte_rdy = 1'b0;
        tick();
        tick();
        check_val("rst_vld",   {39'h0, bus.byte_vld},   40'h0);
        check_val("rst_byte",  {32'h0, bus.byte_out},   40'h0);
        check_val("rst_err",   {39'h0, bus.frame_err},  40'h0);
        check_val("rst_drop",  {39'h0, bus.frame_drop}, 40'h0);
        check_val("rst_level", {35'h0, bus.fifo_level}, 40'h0);
        rst = 1'b0;
        tick();

        // 1. basic frame, consumer always ready
        bus.byte_rdy = 1'b1;
        strobe(40'hFF_17_18_19_FF);
        check_val("t1_vld_n1", {39'h0, bus.byte_vld},   40'h0);
        check_val("t1_err",    {39'h0, bus.frame_err},  40'h0);
        check_val("t1_drop",   {39'h0, bus.frame_drop}, 40'h0);
        tick();
        check_val("t1_vld_n2", {39'h0, bus.byte_vld},   40'h1);
        check_val("t1_b0",     {32'h0, bus.byte_out},   40'h17);
        tick();
        check_val("t1_b1",     {32'h0, bus.byte_out},   40'h18);
        tick();
        check_val("t1_b2",     {32'h0, bus.byte_out},   40'h19);
        tick();
        check_val("t1_empty",  {39'h0, bus.byte_vld},   40'h0);
`ifdef QPSK_PARSER_STATS_EN
        check_val("t1_okcnt",  {24'h0, ok_cnt},  40'h1);
        check_val("t1_errcnt", {24'h0, err_cnt}, 40'h0);
`endif

        // 2. bad header then bad tail
        strobe(40'hFE_17_18_19_FF);
        check_val("t2_err_hdr",  {39'h0, bus.frame_err},  40'h1);
        check_val("t2_drop_hdr", {39'h0, bus.frame_drop}, 40'h0);
        tick();
        check_val("t2_err_pulse", {39'h0, bus.frame_err}, 40'h0);
        strobe(40'hFF_17_18_19_00);
        check_val("t2_err_tail",  {39'h0, bus.frame_err}, 40'h1);
        tick();
        tick();
        check_val("t2_level", {35'h0, bus.fifo_level}, 40'h0);
        check_val("t2_vld",   {39'h0, bus.byte_vld},   40'h0);
`ifdef QPSK_PARSER_STATS_EN
        check_val("t2_errcnt", {24'h0, err_cnt}, 40'h2);
`endif

        // 3. back-pressure until full, sixth frame dropped
        bus.byte_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(mk_frame(8'(8'h20 + 3 * i), 8'(8'h21 + 3 * i), 8'(8'h22 + 3 * i)));
            tick();
            tick();
            tick();
        end
        check_val("t3_level15", {35'h0, bus.fifo_level}, 40'd15);
        check_val("t3_head",    {32'h0, bus.byte_out},   40'h20);
        strobe(mk_frame(8'hAA, 8'hBB, 8'hCC));
        check_val("t3_drop", {39'h0, bus.frame_drop}, 40'h1);
        check_val("t3_err",  {39'h0, bus.frame_err},  40'h0);
        tick();
        check_val("t3_drop_pulse", {39'h0, bus.frame_drop}, 40'h0);
        tick();
        tick();
        check_val("t3_level_hold", {35'h0, bus.fifo_level}, 40'd15);
        check_val("t3_head_hold",  {32'h0, bus.byte_out},   40'h20);

        // 5. level 14 with a same-cycle pop still admits a frame
        bus.byte_rdy = 1'b1;
        tick();
        check_val("t5_level14", {35'h0, bus.fifo_level}, 40'd14);
        check_val("t5_head",    {32'h0, bus.byte_out},   40'h21);
        strobe(mk_frame(8'h51, 8'h52, 8'h53));
        bus.byte_rdy = 1'b0;
        check_val("t5_nodrop",  {39'h0, bus.frame_drop}, 40'h0);
        check_val("t5_level13", {35'h0, bus.fifo_level}, 40'd13);
        tick();
        tick();
        tick();
        check_val("t5_full",    {35'h0, bus.fifo_level}, 40'd16);
        check_val("t5_head2",   {32'h0, bus.byte_out},   40'h22);

        // drain, bounded
        bus.byte_rdy = 1'b1;
        for (int i = 0; i < 40 && bus.byte_vld; i++) tick();
        check_val("drain_level", {35'h0, bus.fifo_level}, 40'h0);

        // 4. busy drop: second strobe two cycles after the first
        strobe(mk_frame(8'h61, 8'h62, 8'h63));
        tick();
        check_val("t4_b0", {32'h0, bus.byte_out}, 40'h61);
        strobe(mk_frame(8'h71, 8'h72, 8'h73));
        check_val("t4_drop", {39'h0, bus.frame_drop}, 40'h1);
        check_val("t4_b1",   {32'h0, bus.byte_out},   40'h62);
        tick();
        check_val("t4_b2",   {32'h0, bus.byte_out},   40'h63);
        tick();
        check_val("t4_done", {39'h0, bus.byte_vld},   40'h0);
        tick();
        tick();
        check_val("t4_still_empty", {35'h0, bus.fifo_level}, 40'h0);

        // 6. reset while in PUSH1
        bus.byte_rdy = 1'b0;
        strobe(mk_frame(8'h81, 8'h82, 8'h83));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t6_vld",   {39'h0, bus.byte_vld},   40'h0);
        check_val("t6_level", {35'h0, bus.fifo_level}, 40'h0);
        check_val("t6_drop",  {39'h0, bus.frame_drop}, 40'h0);
`ifdef QPSK_PARSER_STATS_EN
        check_val("t6_okcnt",  {24'h0, ok_cnt},  40'h0);
        check_val("t6_errcnt", {24'h0, err_cnt}, 40'h0);
`endif
        tick();
        tick();
        check_val("t6_no_residue", {35'h0, bus.fifo_level}, 40'h0);
        bus.byte_rdy = 1'b1;
        strobe(mk_frame(8'h91, 8'h92, 8'h93));
        tick();
        check_val("t6_b0", {32'h0, bus.byte_out}, 40'h91);
        tick();
        check_val("t6_b1", {32'h0, bus.byte_out}, 40'h92);
        tick();
        check_val("t6_b2", {32'h0, bus.byte_out}, 40'h93);
        tick();
        check_val("t6_empty", {39'h0, bus.byte_vld}, 40'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
